// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit and its prefetch buffer.
package fetch_pkg;

  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;
  localparam int unsigned DefaultDepth   = 2;

  typedef enum logic {
    StRun,
    StFlush
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: small circular FIFO of fetched instructions with flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned Depth = DefaultDepth,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            flush_i,
  input  logic            push_i,
  input  fetch_entry_t    entry_i,
  input  logic            pop_i,
  output fetch_entry_t    head_o,
  output logic [CntW-1:0] count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic            pop_ok, push_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign pop_ok  = pop_i & (count_q != '0);
  // A simultaneous pop frees the head slot, so a push into a full buffer is legal then.
  assign push_ok = push_i & ((count_q < CntW'(Depth)) | pop_ok);

  always_ff @(posedge clk_i) begin
    if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= entry_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches, buffers responses, handles redirects.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefaultResetPc,
  parameter int unsigned DEPTH    = DefaultDepth
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  fetch_state_e    state_q;
  logic [31:0]     fetch_pc_q, inflight_pc_q;
  logic            inflight_q;
  logic [CntW-1:0] count;
  logic [CntW:0]   occupancy, limit;
  logic            pop, push, flush;
  fetch_entry_t    head, push_entry;

  assign instr_valid = rst & ~redirect_valid & (count != '0);
  assign pop         = instr_valid & instr_ready;

  // Issue only if the buffer can still absorb every outstanding response after this pop.
  assign occupancy = {1'b0, count} + {{CntW{1'b0}}, inflight_q};
  assign limit     = (CntW + 1)'(DEPTH) + {{CntW{1'b0}}, pop};
  assign imem_req  = rst & (state_q == StRun) & ~redirect_valid & (occupancy < limit);
  assign imem_addr = fetch_pc_q;

  // A response returning in a redirect or reset cycle is killed.
  assign push       = rst & ~redirect_valid & inflight_q;
  assign flush      = ~rst | redirect_valid;
  assign push_entry = '{pc: inflight_pc_q, instr: imem_rdata};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StRun;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      state_q    <= StFlush;
      fetch_pc_q <= {redirect_pc[31:2], 2'b00};
      inflight_q <= 1'b0;
    end else begin
      state_q    <= StRun;
      inflight_q <= imem_req;
      if (imem_req) begin
        inflight_pc_q <= fetch_pc_q;
        fetch_pc_q    <= fetch_pc_q + 32'd4;
      end
    end
  end

  fetch_fifo #(
    .Depth(DEPTH),
    .CntW (CntW)
  ) u_fifo (
    .clk_i  (clk),
    .flush_i(flush),
    .push_i (push),
    .entry_i(push_entry),
    .pop_i  (pop),
    .head_o (head),
    .count_o(count)
  );

  assign instr    = head.instr;
  assign instr_pc = head.pc;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the number of prefetch buffer entries; 2 is the only supported value.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-low reset.
REQ-005 The block SHALL have port imem_req, output, 1, instruction memory read request.
REQ-006 The block SHALL have port imem_addr, output, 32, instruction memory read address, word aligned.
REQ-007 The block SHALL have port imem_rdata, input, 32, instruction word, valid exactly one cycle after the accepted imem_req.
REQ-008 The block SHALL have port redirect_valid, input, 1, taken branch or jump from execute.
REQ-009 The block SHALL have port redirect_pc, input, 32, target address for the redirect.
REQ-010 The block SHALL have port instr_valid, output, 1, decode-side valid.
REQ-011 The block SHALL have port instr_ready, input, 1, decode-side ready.
REQ-012 The block SHALL have port instr, output, 32, instruction word at the buffer head.
REQ-013 The block SHALL have port instr_pc, output, 32, address of instr.

Function
REQ-014 The block SHALL keep state: fetch_pc (32), buffer count c (0..2), in-flight flag i (0/1), and FSM state {S_RUN, S_FLUSH}.
REQ-015 imem_req SHALL be 1 iff state==S_RUN, rst==1, redirect_valid==0, and (c + i - pop) < DEPTH, where pop = instr_valid & instr_ready.
REQ-016 imem_addr SHALL equal fetch_pc whenever imem_req is 1.
REQ-017 On each issued request, fetch_pc SHALL advance by 4 and wrap modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
REQ-018 On the cycle after an issued request, imem_rdata SHALL be pushed with its address unless that response was killed (REQ-022).
REQ-019 instr_valid SHALL be 1 iff c != 0 and redirect_valid == 0.
REQ-020 A pop SHALL remove the head entry; push and pop in the same cycle SHALL be legal at any count, with order preserved.
REQ-021 With instr_ready held at 1 and no redirects, throughput SHALL be one instruction per cycle, and latency from request to instr_valid SHALL be 2 cycles.
REQ-022 On redirect_valid==1: the buffer SHALL be flushed (c=0), any in-flight response SHALL be dropped, fetch_pc SHALL load {redirect_pc[31:2],2'b00}, and state SHALL go to S_FLUSH.
REQ-023 S_FLUSH SHALL last exactly one cycle, issue no request, and return to S_RUN; the first request at the target SHALL occur in the cycle after S_FLUSH.
REQ-024 A redirect during S_FLUSH SHALL take effect and restart S_FLUSH (last redirect wins).
REQ-025 Back-pressure (instr_ready==0) SHALL hold instr and instr_pc stable while instr_valid is 1; the buffer SHALL never overflow.

Reset
REQ-026 While rst==0: fetch_pc=RESET_PC, c=0, i=0, state=S_RUN, imem_req=0, instr_valid=0, and redirect_valid SHALL be ignored.
REQ-027 After rst returns to 1, the first request SHALL be issued in that same cycle with imem_addr=RESET_PC.
REQ-028 Reset asserted mid-operation SHALL discard buffered and in-flight instructions, with no push on the following cycle.

Structure
REQ-029 Package fetch_pkg SHALL hold RESET_PC default, DEPTH default, the FSM state enum, and a fetch entry struct {pc[31:0], instr[31:0]}.
REQ-030 The buffer SHALL be a sub-module fetch_fifo (DEPTH entries of the fetch entry struct, push/pop/flush, count output).
REQ-031 RTL SHALL be 120-400 lines in total.

Verification
REQ-032 Reset release with RESET_PC=0 and instr_ready=1 -> imem_addr 0,4,8 on consecutive cycles; instr_pc 0 appears 2 cycles after release, then one instruction per cycle.
REQ-033 instr_ready=0 for 5 cycles -> at most 2 requests issued, then imem_req=0; instr/instr_pc stay stable; raising ready resumes full rate with no loss or duplication.
REQ-034 redirect_pc=0x100 while c=2 and i=1 -> instr_valid=0 that cycle; next cycle no request; following cycle imem_addr=0x100; no stale instruction is ever delivered.
REQ-035 redirect_pc=0x203 -> fetch resumes at 0x200; fetching past 0xFFFF_FFFC -> next imem_addr is 0x0000_0000.
REQ-036 rst=0 for one cycle mid-stream with 2 buffered -> instr_valid=0 through reset; after release, fetch restarts at RESET_PC.
REQ-037 Redirects on two consecutive cycles (0x40 then 0x80) -> first fetch is at 0x80; nothing is fetched from 0x40.
